sarlock_key_loader: RTL
=======================

// Module: sarlock_key_loader
// PURPOSE
//  Supplies the 32-bit unlock key to a SARLock-locked netlist such as c432_sarlock_32k.
//  The key arrives as a checksummed bit-serial stream from the secure key store.
//  - Key is staged, verified, then presented on key_out (drives keyinput0..31).
//  - key_out stays all-zero whenever the key is not verified; a partial key never reaches the locked logic.
//  - Repeated bad loads latch a permanent lockout.
// PARAMETERS
//  KEY_W      32  key width; must equal the locked netlist's keyinput count
//  CHK_W      8   checksum width; KEY_W % CHK_W == 0 required (elaboration-time check)
//  MAX_TRIES  3   consecutive failed loads that trigger LOCKOUT; must be >= 1
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            reset, asynchronous, active-high
//  s_valid    in   1            serial bit valid
//  s_data     in   1            serial bit; stream order is key MSB-first, then checksum MSB-first
//  s_last     in   1            marks the final bit of the frame
//  s_ready    out  1            loader can accept a bit this cycle
//  clear_req  in   1            zeroize request; honoured only in ARMED
//  key_out    out  KEY_W        verified key; bit i drives keyinput<i>
//  key_valid  out  1            key_out holds a verified key
//  load_err   out  1            one-cycle pulse per rejected frame
//  lockout    out  1            sticky; cleared only by rst
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is asynchronous and active-high.
//  Reset values: all state registers zeroed and FSM = IDLE.
//    Outputs: key_out=0, key_valid=0, load_err=0, lockout=0, s_ready=1.
//  Handshake: a bit is accepted when s_valid && s_ready. Only registered state drives s_ready.
//    s_ready=1 in IDLE and SHIFT only; 0 in CHECK, ERROR, ARMED and LOCKOUT.
//  Frame length: FRAME = KEY_W+CHK_W bits. bit_cnt is $clog2(FRAME+1) bits wide and counts accepted bits.
//  FSM states and transitions:
//    IDLE:
//      - Accepted bit -> SHIFT, bit shifted into staging, bit_cnt=1.
//      - If that bit also has s_last=1 -> ERROR (frame too short).
//    SHIFT:
//      - Each accepted bit shifts into the staging register (FRAME bits, shift left, LSB in).
//      - s_last=1 on bit number FRAME -> CHECK.
//      - s_last=1 earlier -> ERROR.
//      - Bit number FRAME accepted with s_last=0 -> ERROR (too long).
//      - s_valid low simply stalls; there is no timeout.
//    CHECK (1 cycle):
//      - exp = XOR-fold of staged key into CHK_W-bit chunks.
//      - exp == staged checksum -> ARMED; key_out <= staged key and key_valid <= 1 on the transition edge.
//      - Otherwise -> ERROR.
//    ERROR (1 cycle):
//      - load_err=1; fail_cnt += 1 (saturating); staging and bit_cnt cleared.
//      - fail_cnt == MAX_TRIES after increment -> LOCKOUT, else -> IDLE.
//    ARMED:
//      - key_out held stable; fail_cnt cleared.
//      - clear_req=1 -> IDLE next cycle with key_out=0, key_valid=0 and staging zeroized.
//      - Serial input is ignored.
//    LOCKOUT: absorbing state; lockout=1, key_out=0, key_valid=0, s_ready=0. Exit only via rst.
//  Latency: last bit accepted at cycle N; CHECK at N+1; key_valid=1 and key_out valid from N+2.
//  clear_req outside ARMED is ignored. s_data and s_last are don't-care when s_valid=0.
//  Reset mid-frame or while ARMED: immediate zeroize of key_out and staging. fail_cnt returns to 0.
// STRUCTURE
//  Package sarlock_key_pkg holds:
//    - the state enum {IDLE,SHIFT,CHECK,ERROR,ARMED,LOCKOUT}
//    - function chk_fold(key) -> CHK_W XOR-fold
//    - localparam FRAME
//  Single FSM module, no sub-modules; chk_fold is purely combinational and used in CHECK only.
//  key_out is a dedicated register, separate from staging; it is written only on CHECK->ARMED.
// TESTING
//  1. Good load, gap-free:
//     - Stimulus: key 32'h9B1C_A35B, chk 8'h7F (9B^1C^A3^5B); s_last on bit 40.
//     - Required: key_valid=1 and key_out=32'h9B1C_A35B exactly 2 cycles after bit 40; no load_err.
//  2. Bad checksum:
//     - Stimulus: same key with chk 8'h7E.
//     - Required: one load_err pulse at N+2; key_out stays 0; returns to IDLE with s_ready=1.
//  3. Length errors:
//     - Stimulus A: s_last on bit 39.
//     - Stimulus B: 40 bits with no s_last.
//     - Required: each gives a load_err pulse, and key_out=0.
//  4. Lockout:
//     - Stimulus: 3 consecutive bad frames, then a good frame.
//     - Required: lockout=1 after the 3rd; s_ready=0; good frame ignored; rst clears all.
//  5. Stalls and clear:
//     - Stimulus: good frame with random s_valid gaps; then clear_req pulse in ARMED.
//     - Required: identical key_out; next cycle key_out=0, key_valid=0, s_ready=1.
//  6. Async reset:
//     - Stimulus: assert rst mid-frame (bit 17) and again while ARMED, off the clock edge.
//     - Required: outputs zero immediately; a fresh good frame then loads normally.

Source files
------------

// File: rtl/sarlock_key_pkg.sv
// Shared types and helpers for the SARLock key loader: FSM state encoding,
// default frame geometry and the checksum fold used to verify a staged key.
package sarlock_key_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      CHECK   = 3'd2,
      ERROR   = 3'd3,
      ARMED   = 3'd4,
      LOCKOUT = 3'd5
   } state_e;

   // Default geometry matching a 32-keyinput locked netlist with an 8-bit checksum.
   localparam int unsigned KEY_W_DFLT = 32;
   localparam int unsigned CHK_W_DFLT = 8;
   localparam int unsigned FRAME      = KEY_W_DFLT + CHK_W_DFLT;

   // Upper bounds the fold helper can handle; the loader checks its parameters against them.
   localparam int unsigned FOLD_KEY_MAX = 256;
   localparam int unsigned FOLD_CHK_MAX = 64;
   localparam int unsigned FOLD_KEY_IW  = $clog2(FOLD_KEY_MAX);
   localparam int unsigned FOLD_CHK_IW  = $clog2(FOLD_CHK_MAX);

   // XOR-fold of the low key_w bits of key into chk_w-bit chunks. Key bit i lands on
   // checksum bit (i mod chk_w), which is the same as XOR-ing the aligned chunks together.
   // Result bits at or above chk_w are always zero.
   function automatic logic [FOLD_CHK_MAX-1:0] chk_fold(
      input logic [FOLD_KEY_MAX-1:0] key,
      input int unsigned             key_w,
      input int unsigned             chk_w
   );
      logic [FOLD_CHK_MAX-1:0] acc;
      logic [FOLD_CHK_IW-1:0]  cidx;
      logic [FOLD_KEY_IW-1:0]  kidx;
      acc = '0;
      for (int unsigned i = 0; i < FOLD_KEY_MAX; i++) begin
         if (i < key_w) begin
            cidx      = FOLD_CHK_IW'(i % chk_w);
            kidx      = FOLD_KEY_IW'(i);
            acc[cidx] = acc[cidx] ^ key[kidx];
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/sarlock_key_loader.sv
// Bit-serial key loader for a SARLock-locked netlist. A frame (key MSB-first, then
// checksum MSB-first) is staged, length- and checksum-verified, and only then copied
// into the dedicated key_out register. Repeated bad frames latch a permanent lockout.
module sarlock_key_loader
   import sarlock_key_pkg::*;
#(
   parameter int unsigned KEY_W     = 32,
   parameter int unsigned CHK_W     = 8,
   parameter int unsigned MAX_TRIES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic             s_data,
   input  logic             s_last,
   output logic             s_ready,
   input  logic             clear_req,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             load_err,
   output logic             lockout
);

   localparam int unsigned FRAME_W = KEY_W + CHK_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
   localparam int unsigned FC_W    = $clog2(MAX_TRIES + 1);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
   localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(1);
   localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(MAX_TRIES);

   // Reject geometries the loader cannot verify correctly.
   if ((CHK_W == 0) || (KEY_W % CHK_W != 0)) begin : g_bad_ratio
      $error("sarlock_key_loader: KEY_W must be a non-zero multiple of CHK_W");
   end
   if (MAX_TRIES < 1) begin : g_bad_tries
      $error("sarlock_key_loader: MAX_TRIES must be at least 1");
   end
   if ((KEY_W > FOLD_KEY_MAX) || (CHK_W > FOLD_CHK_MAX)) begin : g_bad_fold
      $error("sarlock_key_loader: key or checksum wider than chk_fold supports");
   end

   state_e             state_q, state_d;
   logic [FRAME_W-1:0] stage_q, stage_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [FC_W-1:0]    fail_q,  fail_d;
   logic [KEY_W-1:0]   key_q,   key_d;
   logic               kv_q,    kv_d;

   logic [FRAME_W-1:0]      stage_shift_s;
   logic [CNT_W-1:0]        cnt_inc_s;
   logic [FC_W-1:0]         fail_inc_s;
   logic [FOLD_KEY_MAX-1:0] fold_in_s;
   logic [FOLD_CHK_MAX-1:0] fold_exp_s;
   logic [FOLD_CHK_MAX-1:0] staged_chk_s;
   logic                    chk_ok_s;

   // Handshake and status outputs come straight from registered state.
   assign s_ready   = (state_q == IDLE) || (state_q == SHIFT);
   assign load_err  = (state_q == ERROR);
   assign lockout   = (state_q == LOCKOUT);
   assign key_out   = key_q;
   assign key_valid = kv_q;

   assign stage_shift_s = {stage_q[FRAME_W-2:0], s_data};
   assign cnt_inc_s     = cnt_q + CNT_ONE;
   assign fail_inc_s    = (fail_q < FC_MAX) ? (fail_q + FC_ONE) : fail_q;

   // Checksum verification of the staged frame; only consulted while in CHECK.
   always_comb begin
      fold_in_s                 = '0;
      fold_in_s[KEY_W-1:0]      = stage_q[FRAME_W-1:CHK_W];
      staged_chk_s              = '0;
      staged_chk_s[CHK_W-1:0]   = stage_q[CHK_W-1:0];
      fold_exp_s                = chk_fold(fold_in_s, KEY_W, CHK_W);
      chk_ok_s                  = (fold_exp_s == staged_chk_s);
   end

   // Next-state logic: frame staging, length/checksum verdicts, key release and lockout.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      key_d   = key_q;
      kv_d    = kv_q;
      case (state_q)
         IDLE: begin
            if (s_valid) begin
               stage_d = stage_shift_s;
               cnt_d   = CNT_ONE;
               if (s_last) begin
                  state_d = ERROR;          // single-bit frame is always too short
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (s_valid) begin
               stage_d = stage_shift_s;
               cnt_d   = cnt_inc_s;
               if (s_last) begin
                  if (cnt_inc_s == CNT_FRAME) begin
                     state_d = CHECK;
                  end else begin
                     state_d = ERROR;       // frame ended early
                  end
               end else if (cnt_inc_s == CNT_FRAME) begin
                  state_d = ERROR;          // full frame without end marker
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = SHIFT;             // stall, no timeout
            end
         end
         CHECK: begin
            if (chk_ok_s) begin
               state_d = ARMED;
               key_d   = stage_q[FRAME_W-1:CHK_W];
               kv_d    = 1'b1;
            end else begin
               state_d = ERROR;
            end
         end
         ERROR: begin
            stage_d = '0;
            cnt_d   = '0;
            fail_d  = fail_inc_s;
            if (fail_inc_s == FC_MAX) begin
               state_d = LOCKOUT;
            end else begin
               state_d = IDLE;
            end
         end
         ARMED: begin
            fail_d = '0;
            if (clear_req) begin
               state_d = IDLE;
               stage_d = '0;
               cnt_d   = '0;
               key_d   = '0;
               kv_d    = 1'b0;
            end else begin
               state_d = ARMED;
            end
         end
         LOCKOUT: begin
            state_d = LOCKOUT;
            stage_d = '0;
            cnt_d   = '0;
            key_d   = '0;
            kv_d    = 1'b0;
         end
         default: begin
            state_d = IDLE;
            stage_d = '0;
            cnt_d   = '0;
            fail_d  = '0;
            key_d   = '0;
            kv_d    = 1'b0;
         end
      endcase
   end

   // State registers; reset zeroizes the key and staging immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         stage_q <= '0;
         cnt_q   <= '0;
         fail_q  <= '0;
         key_q   <= '0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         fail_q  <= fail_d;
         key_q   <= key_d;
         kv_q    <= kv_d;
      end
   end

endmodule
